// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with a Start/Busy/Done handshake.
// Logic, add/sub, signed compare and shifts finish in one cycle. Unsigned
// multiply (shift-add) and divide (restoring) take WIDTH cycles each.
// Every result and flag is held in a register between Done pulses.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             AInvert,
  input  logic [3:0]       Op,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Zero,
  output logic             Overflow,
  output logic             CarryOut,
  output logic             DivByZero,
  output logic             Busy,
  output logic             Done
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b1100;
  localparam logic [3:0] OP_SLT = 4'b0001;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;

  // The step counter runs 0 .. WIDTH-1; the step taken at WIDTH-1 is the last.
  localparam logic [SHW:0] LAST_STEP = (SHW+1)'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic                 last_step_s;

  logic [SHW:0]         cnt_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]     opa_r;
  logic [WIDTH-1:0]     opb_r;

  logic [WIDTH-1:0]     result_r;
  logic [WIDTH-1:0]     result_hi_r;
  logic                 zero_r;
  logic                 ovf_r;
  logic                 cout_r;
  logic                 dbz_r;
  logic                 busy_r;
  logic                 done_r;

  // Single-cycle datapath signals
  logic [WIDTH-1:0]     a_eff_s;
  logic [SHW-1:0]       shamt_s;
  logic [WIDTH:0]       add_s;
  logic [WIDTH:0]       sub_s;
  logic                 add_ovf_s;
  logic                 sub_ovf_s;
  logic [WIDTH-1:0]     res_s;
  logic                 ovf_s;
  logic                 cout_s;

  // Iterative datapath signals
  logic [WIDTH:0]       mul_add_s;
  logic [2*WIDTH-1:0]   mul_next_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH:0]       div_diff_s;
  logic [2*WIDTH-1:0]   div_next_s;

  assign Result    = result_r;
  assign ResultHi  = result_hi_r;
  assign Zero      = zero_r;
  assign Overflow  = ovf_r;
  assign CarryOut  = cout_r;
  assign DivByZero = dbz_r;
  assign Busy      = busy_r;
  assign Done      = done_r;

  // Single-cycle result and flags, computed from the live operand inputs.
  always_comb begin
    a_eff_s   = AInvert ? ~A : A;
    shamt_s   = B[SHW-1:0];
    add_s     = {1'b0, a_eff_s} + {1'b0, B};
    sub_s     = {1'b0, a_eff_s} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    // Overflow when operands (B inverted for subtract) agree in sign but the sum does not.
    add_ovf_s = (a_eff_s[WIDTH-1] == B[WIDTH-1]) && (add_s[WIDTH-1] != a_eff_s[WIDTH-1]);
    sub_ovf_s = (a_eff_s[WIDTH-1] != B[WIDTH-1]) && (sub_s[WIDTH-1] != a_eff_s[WIDTH-1]);
    res_s     = {WIDTH{1'b0}};
    ovf_s     = 1'b0;
    cout_s    = 1'b0;
    case (Op)
      OP_AND: res_s = a_eff_s & B;
      OP_OR:  res_s = a_eff_s | B;
      OP_XOR: res_s = a_eff_s ^ B;
      OP_ADD: begin
        res_s  = add_s[WIDTH-1:0];
        cout_s = add_s[WIDTH];
        ovf_s  = add_ovf_s;
      end
      OP_SUB: begin
        res_s  = sub_s[WIDTH-1:0];
        cout_s = sub_s[WIDTH];
        ovf_s  = sub_ovf_s;
      end
      OP_SLT: res_s = {{(WIDTH-1){1'b0}}, sub_s[WIDTH-1] ^ sub_ovf_s};
      OP_SLL: res_s = A << shamt_s;
      OP_SRL: res_s = A >> shamt_s;
      OP_SRA: res_s = $signed(A) >>> shamt_s;
      default: res_s = {WIDTH{1'b0}};
    endcase
  end

  // One multiply step and one divide step, derived from the accumulator.
  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier}; add A when LSB set, shift right.
    mul_add_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                  (acc_r[0] ? {1'b0, opa_r} : {(WIDTH+1){1'b0}});
    mul_next_s  = {mul_add_s, acc_r[WIDTH-1:1]};
    // Divide: acc = {remainder, dividend bits still to shift in}; restore on negative trial.
    div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opb_r};
    div_next_s  = div_diff_s[WIDTH] ?
                  {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0} :
                  {div_diff_s[WIDTH-1:0],  acc_r[WIDTH-2:0], 1'b1};
  end

  // Next-state logic: IDLE accepts Start, MUL/DIV run until the last step.
  always_comb begin
    state_s     = state_r;
    last_step_s = (cnt_r == LAST_STEP);
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          state_s = (Op == OP_MUL) ? ST_MUL :
                    (Op == OP_DIV) ? ST_DIV : ST_IDLE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL:  state_s = last_step_s ? ST_IDLE : ST_MUL;
      ST_DIV:  state_s = last_step_s ? ST_IDLE : ST_DIV;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register; Reset wins over any Start on the same edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, iterative steps and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_r       <= {(SHW+1){1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      opa_r       <= {WIDTH{1'b0}};
      opb_r       <= {WIDTH{1'b0}};
      result_r    <= {WIDTH{1'b0}};
      result_hi_r <= {WIDTH{1'b0}};
      zero_r      <= 1'b1;
      ovf_r       <= 1'b0;
      cout_r      <= 1'b0;
      dbz_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (Start) begin
            if (Op == OP_MUL) begin
              acc_r  <= {{WIDTH{1'b0}}, B};
              opa_r  <= A;
              opb_r  <= B;
              cnt_r  <= {(SHW+1){1'b0}};
              busy_r <= 1'b1;
            end else if (Op == OP_DIV) begin
              acc_r  <= {{WIDTH{1'b0}}, A};
              opa_r  <= A;
              opb_r  <= B;
              cnt_r  <= {(SHW+1){1'b0}};
              busy_r <= 1'b1;
              // Divide-by-zero is visible from the accepting edge onwards.
              if (B == {WIDTH{1'b0}}) begin
                dbz_r <= 1'b1;
              end
            end else begin
              result_r    <= res_s;
              result_hi_r <= {WIDTH{1'b0}};
              zero_r      <= (res_s == {WIDTH{1'b0}});
              ovf_r       <= ovf_s;
              cout_r      <= cout_s;
              dbz_r       <= 1'b0;
              done_r      <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          acc_r <= mul_next_s;
          cnt_r <= cnt_r + {{SHW{1'b0}}, 1'b1};
          if (last_step_s) begin
            result_r    <= mul_next_s[WIDTH-1:0];
            result_hi_r <= mul_next_s[2*WIDTH-1:WIDTH];
            zero_r      <= (mul_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
            ovf_r       <= (mul_next_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
            cout_r      <= 1'b0;
            dbz_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
          end
        end
        ST_DIV: begin
          acc_r <= div_next_s;
          cnt_r <= cnt_r + {{SHW{1'b0}}, 1'b1};
          if (last_step_s) begin
            if (opb_r == {WIDTH{1'b0}}) begin
              // Defined divide-by-zero result: all-ones quotient, dividend as remainder.
              result_r    <= {WIDTH{1'b1}};
              result_hi_r <= opa_r;
              zero_r      <= 1'b0;
              dbz_r       <= 1'b1;
            end else begin
              result_r    <= div_next_s[WIDTH-1:0];
              result_hi_r <= div_next_s[2*WIDTH-1:WIDTH];
              zero_r      <= (div_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
              dbz_r       <= 1'b0;
            end
            ovf_r  <= 1'b0;
            cout_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, hand-written handshake/reset sequences
// and randomized operations checked against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 16;

  logic          Clock;
  logic          Reset;
  logic          Start;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          AInvert;
  logic [3:0]    Op;
  logic [W-1:0]  Result;
  logic [W-1:0]  ResultHi;
  logic          Zero;
  logic          Overflow;
  logic          CarryOut;
  logic          DivByZero;
  logic          Busy;
  logic          Done;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .A(A), .B(B),
    .AInvert(AInvert), .Op(Op), .Result(Result), .ResultHi(ResultHi),
    .Zero(Zero), .Overflow(Overflow), .CarryOut(CarryOut),
    .DivByZero(DivByZero), .Busy(Busy), .Done(Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         ovf;
    logic         cout;
    logic         dbz;
    int           lat;
  } exp_t;

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ainv;
    exp_t         e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the operation definitions, using integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic ainv);
    exp_t         e;
    logic [W-1:0] ae;
    int           sa, sb, s, sh, sra_v;
    int unsigned  ua, ub, u;
    longint unsigned p;
    ae = ainv ? ~a : a;
    sa = $signed(ae);
    sb = $signed(b);
    ua = ae;
    ub = b;
    sh = b % W;
    e = '{res: 16'h0000, hi: 16'h0000, ovf: 1'b0, cout: 1'b0, dbz: 1'b0, lat: 0};
    case (op)
      4'b0000: e.res = ae & b;
      4'b0010: e.res = ae | b;
      4'b0011: e.res = ae ^ b;
      4'b0100: begin
        u = ua + ub;
        e.res = u[W-1:0];
        e.cout = (u > 32'd65535);
        s = sa + sb;
        e.ovf = (s > 32767) || (s < -32768);
      end
      4'b1100: begin
        u = ua + (32'd65535 - ub) + 32'd1;
        e.res = u[W-1:0];
        e.cout = (u > 32'd65535);
        s = sa - sb;
        e.ovf = (s > 32767) || (s < -32768);
      end
      4'b0001: e.res = (sa < sb) ? 16'h0001 : 16'h0000;
      4'b0101: e.res = a << sh;
      4'b0110: e.res = a >> sh;
      4'b0111: begin
        sra_v = $signed(a);
        sra_v = sra_v >>> sh;
        e.res = sra_v[W-1:0];
      end
      4'b1000: begin
        p = longint'(a) * longint'(b);
        e.res = p[W-1:0];
        e.hi  = p[2*W-1:W];
        e.ovf = (p > 64'd65535);
        e.lat = W;
      end
      4'b1001: begin
        e.lat = W;
        if (b == 16'h0000) begin
          e.res = 16'hFFFF;
          e.hi  = a;
          e.dbz = 1'b1;
        end else begin
          e.res = a / b;
          e.hi  = a % b;
        end
      end
      default: e.res = 16'h0000;
    endcase
    return e;
  endfunction

  // Issue one operation and wait (bounded) for Done; returns latency and busy cycles.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ainv, output int lat, output int busy_cnt);
    Op = op; A = a; B = b; AInvert = ainv; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!Done && lat < 40) begin
      if (Busy) busy_cnt++;
      @(posedge Clock); #1;
      lat++;
    end
  endtask

  task automatic check_out(input string tag, input exp_t e, input int lat, input int busy_cnt);
    chk({tag, " Result"},    Result,    e.res);
    chk({tag, " ResultHi"},  ResultHi,  e.hi);
    chk({tag, " Zero"},      Zero,      (e.res == 16'h0000));
    chk({tag, " Overflow"},  Overflow,  e.ovf);
    chk({tag, " CarryOut"},  CarryOut,  e.cout);
    chk({tag, " DivByZero"}, DivByZero, e.dbz);
    chk({tag, " latency"},   lat,       e.lat);
    chk({tag, " busy"},      busy_cnt,  e.lat);
    chk({tag, " Busy@Done"}, Busy,      1'b0);
  endtask

  vec_t vecs[12];
  logic [3:0] codes[16];

  initial begin
    int lat, bc;
    exp_t e;
    logic [3:0] rop;
    logic [W-1:0] ra, rb;
    logic rinv;

    vecs[0]  = '{"add_ovf",  4'b0100, 16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0, 0}};
    vecs[1]  = '{"sub",      4'b1100, 16'd100,  16'd95,   1'b0, '{16'h0005, 16'h0000, 1'b0, 1'b1, 1'b0, 0}};
    vecs[2]  = '{"slt_ovf",  4'b0001, 16'h8000, 16'h0001, 1'b0, '{16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 0}};
    vecs[3]  = '{"sra",      4'b0111, 16'h8000, 16'h0003, 1'b0, '{16'hF000, 16'h0000, 1'b0, 1'b0, 1'b0, 0}};
    vecs[4]  = '{"sll_hi_b", 4'b0101, 16'h0001, 16'h0013, 1'b0, '{16'h0008, 16'h0000, 1'b0, 1'b0, 1'b0, 0}};
    vecs[5]  = '{"and",      4'b0000, 16'hF0F0, 16'h0FF0, 1'b0, '{16'h00F0, 16'h0000, 1'b0, 1'b0, 1'b0, 0}};
    vecs[6]  = '{"and_inv",  4'b0000, 16'h00FF, 16'hFFFF, 1'b1, '{16'hFF00, 16'h0000, 1'b0, 1'b0, 1'b0, 0}};
    vecs[7]  = '{"bad_op",   4'b1010, 16'h1234, 16'h5678, 1'b0, '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 0}};
    vecs[8]  = '{"srl",      4'b0110, 16'h8000, 16'h000F, 1'b0, '{16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 0}};
    vecs[9]  = '{"mul",      4'b1000, 16'd300,  16'd300,  1'b0, '{16'h5F90, 16'h0001, 1'b1, 1'b0, 1'b0, W}};
    vecs[10] = '{"div",      4'b1001, 16'd1000, 16'd7,    1'b0, '{16'd142,  16'd6,    1'b0, 1'b0, 1'b0, W}};
    vecs[11] = '{"div_zero", 4'b1001, 16'h1234, 16'h0000, 1'b0, '{16'hFFFF, 16'h1234, 1'b0, 1'b0, 1'b1, W}};

    codes = '{4'b0000, 4'b0010, 4'b0011, 4'b0100, 4'b1100, 4'b0001, 4'b0101, 4'b0110,
              4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1101, 4'b1110, 4'b1111};

    Reset = 1'b1; Start = 1'b0; A = '0; B = '0; AInvert = 1'b0; Op = 4'b0000;
    repeat (2) @(posedge Clock);
    #1;
    chk("reset Result", Result, 16'h0000);
    chk("reset ResultHi", ResultHi, 16'h0000);
    chk("reset Zero", Zero, 1'b1);
    chk("reset Busy", Busy, 1'b0);
    chk("reset Done", Done, 1'b0);
    chk("reset flags", {Overflow, CarryOut, DivByZero}, 3'b000);
    Reset = 1'b0;

    // Directed table; the last vector leaves DivByZero set.
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ainv, lat, bc);
      check_out(vecs[i].name, vecs[i].e, lat, bc);
    end

    // DivByZero shows up on the accepting edge of a DIV by zero.
    Op = 4'b1001; A = 16'h0042; B = 16'h0000; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    chk("dbz at accept", DivByZero, 1'b1);
    lat = 0;
    while (!Done && lat < 40) begin @(posedge Clock); #1; lat++; end
    chk("dbz2 latency", lat, W);
    chk("dbz2 ResultHi", ResultHi, 16'h0042);

    // Reset in the middle of a MUL: everything clears, DivByZero included.
    Op = 4'b1000; A = 16'd300; B = 16'd300; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (3) begin @(posedge Clock); #1; end
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    chk("midrst Busy", Busy, 1'b0);
    chk("midrst Done", Done, 1'b0);
    chk("midrst Result", Result, 16'h0000);
    chk("midrst Zero", Zero, 1'b1);
    chk("midrst DivByZero", DivByZero, 1'b0);
    repeat (W + 2) begin
      @(posedge Clock); #1;
      chk("midrst no late Done", Done, 1'b0);
    end
    issue(4'b0100, 16'd2, 16'd3, 1'b0, lat, bc);
    check_out("add_after_rst", model(4'b0100, 16'd2, 16'd3, 1'b0), lat, bc);

    // Start while Busy is ignored and not queued.
    Op = 4'b1000; A = 16'd300; B = 16'd300; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (3) begin @(posedge Clock); #1; end
    Op = 4'b0100; A = 16'd1; B = 16'd1; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    lat = 4;
    while (!Done && lat < 40) begin @(posedge Clock); #1; lat++; end
    chk("ign latency", lat, W);
    chk("ign Result", Result, 16'h5F90);
    chk("ign ResultHi", ResultHi, 16'h0001);
    @(posedge Clock); #1;
    chk("ign no queued Done", Done, 1'b0);
    chk("ign no queued Busy", Busy, 1'b0);

    // Back-to-back AND, OR, XOR: three consecutive Done pulses.
    for (int i = 0; i < 3; i++) begin
      Op = (i == 0) ? 4'b0000 : (i == 1) ? 4'b0010 : 4'b0011;
      A = 16'hA5C3; B = 16'h0FF0; AInvert = 1'b0; Start = 1'b1;
      @(posedge Clock); #1;
      chk("b2b Done", Done, 1'b1);
      e = model(Op, 16'hA5C3, 16'h0FF0, 1'b0);
      chk("b2b Result", Result, e.res);
    end
    Start = 1'b0;
    @(posedge Clock); #1;
    chk("b2b Done drops", Done, 1'b0);

    // Reset has priority over Start on the same edge.
    Op = 4'b0100; A = 16'd2; B = 16'd3; Start = 1'b1; Reset = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0; Reset = 1'b0;
    chk("rst_prio Done", Done, 1'b0);
    chk("rst_prio Result", Result, 16'h0000);

    // Randomized operations against the reference model.
    for (int n = 0; n < 250; n++) begin
      rop  = codes[$urandom_range(0, 15)];
      ra   = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
      rb   = ($urandom_range(0, 6) == 0) ? 16'h0000 :
             ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
      rinv = 1'($urandom_range(0, 1));
      issue(rop, ra, rb, rinv, lat, bc);
      check_out("rand", model(rop, ra, rb, rinv), lat, bc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU, successor to the 16-bit single-cycle ALU in the CPU datapath. Width is set by `WIDTH`. The block adds shifts, overflow-correct signed compare, and iterative unsigned multiply and divide. Every result and flag is registered and framed by a Start/Busy/Done handshake. The execute stage of the CPU drives it and stalls while `Busy` is high.

## Interface
- `WIDTH`, 16, operand/result width. Power of two, ≥4.
- `SHW`, `$clog2(WIDTH)`, shift-amount width (derived, not overridden).

- `Clock`  in  1  sole clock, rising edge.
- `Reset`  in  1  synchronous, active-high.
- `Start`  in  1  request. Sampled only when `Busy`=0.
- `A`  in  WIDTH  operand A. Captured on the accepting edge.
- `B`  in  WIDTH  operand B. Captured on the accepting edge.
- `AInvert`  in  1  use ~A for logic/add/sub/slt ops. Ignored for shift, MUL, DIV.
- `Op`  in  4  operation, captured with operands.
- `Result`  out  WIDTH  low result: quotient for DIV, low product half for MUL.
- `ResultHi`  out  WIDTH  high product half (MUL), remainder (DIV), 0 otherwise.
- `Zero`  out  1  `Result`==0.
- `Overflow`  out  1  signed overflow (ADD/SUB); `ResultHi`≠0 (MUL); 0 otherwise.
- `CarryOut`  out  1  MSB carry (ADD/SUB); 0 otherwise.
- `DivByZero`  out  1  DIV with B==0.
- `Busy`  out  1  multi-cycle op in progress.
- `Done`  out  1  one-cycle pulse: outputs updated this cycle.

## Operation
- Op encoding:
  - 0000 AND
  - 0010 OR
  - 0011 XOR
  - 0100 ADD
  - 1100 SUB, computed as A+~B+1
  - 0001 SLT, signed
  - 0101 SLL
  - 0110 SRL
  - 0111 SRA
  - 1000 MUL, unsigned
  - 1001 DIVU
  - Any other code gives `Result`=0 and completes as a single-cycle op.
- Shift amount is B[SHW-1:0]. A is shifted; upper bits of B are ignored.
- SLT: `Result`=1 iff the signed value of A (or ~A) is less than B. Computed as sign(diff) XOR overflow(diff). Upper bits are zero.
- States:
  - IDLE: `Start` with a single-cycle op registers all outputs and pulses `Done`; the block stays in IDLE. `Start` with MUL/DIV loads the operands, clears a SHW+1-bit counter and enters MUL or DIV.
  - MUL: one shift-add step per cycle, LSB-first, 2·WIDTH-bit accumulator. After WIDTH steps it writes `Result`/`ResultHi`/flags, pulses `Done` and returns to IDLE.
  - DIV: one restoring shift-subtract step per cycle, MSB-first. After WIDTH steps it writes quotient/remainder, pulses `Done` and returns to IDLE.
- B==0 on DIV: `DivByZero` is latched at accept. The op still runs WIDTH cycles, then forces `Result`=all-ones and `ResultHi`=A.
- `DivByZero` is cleared on the `Done` of any non-DIV op or of a DIV with B≠0.
- Outputs hold their last values between `Done` pulses.
- `Start` while `Busy`=1 is ignored. No queueing.
- Reset (any state, including mid-op): state goes to IDLE, all outputs go to 0 (`Zero`=1, since `Result`=0), and the counter and accumulators are cleared.

## Timing
- Single-cycle ops: `Start` is accepted at edge N. After edge N, `Done`=1 and the outputs are valid; `Busy` stays 0.
- MUL/DIV: `Start` is accepted at edge N. `Busy`=1 after edges N .. N+WIDTH-1. Steps run on edges N+1 .. N+WIDTH. After edge N+WIDTH, `Done`=1, `Busy`=0 and the outputs are valid. Latency is WIDTH cycles.
- Back-to-back: a new `Start` is accepted on the edge ending the `Done` cycle. The throughput of single-cycle ops is one per clock.
- `Done` is never high for two consecutive cycles except when single-cycle ops are issued back-to-back.
- `Reset` has priority over `Start` on the same edge.

## Test plan
- WIDTH=16: ADD A=0x7FFF B=0x0001 → `Result`=0x8000, `Overflow`=1, `CarryOut`=0, `Done` one cycle after accept. SUB A=100 B=95 → `Result`=5, `CarryOut`=1, `Overflow`=0.
- SLT A=0x8000 B=0x0001 → `Result`=1 (overflowing difference is handled correctly). SRA A=0x8000 B=3 → 0xF000. SLL B=0x0013 → shifts by 3 because the upper bits are ignored.
- MUL A=300 B=300 → after 16 `Busy` cycles, `Result`=0x5F90, `ResultHi`=0x0001, `Overflow`=1. A second `Start` pulsed while `Busy` is ignored.
- DIV A=1000 B=7 → `Result`=142, `ResultHi`=6, `DivByZero`=0. DIV A=0x1234 B=0 → `Result`=0xFFFF, `ResultHi`=0x1234, `DivByZero`=1, latency still 16.
- `Reset` asserted on the 5th cycle of a MUL → next cycle `Busy`=0, `Done`=0, `Result`=0, `Zero`=1. A following ADD 2+3 completes normally with `Result`=5.
- Back-to-back AND, OR, XOR on consecutive cycles → three consecutive `Done` pulses with correct results.
